rng_dispenser: RTL
==================

RNG_DISPENSER -- requirements
Module: rng_dispenser

Interface
REQ-001 SHALL have parameter W, default 32: output word width; legal values divide 96 (8, 16, 24, 32, 48, 96); N = 96/W words per block.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for a PRNG response.
REQ-003 SHALL use a single clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 seed_load  in  1  single-cycle pulse; seed is loaded and the buffer is flushed.
REQ-007 seed  in  96  seed value, sampled when seed_load=1.
REQ-008 prng_req  out  1  PRNG start pulse (drives prng in_ready).
REQ-009 prng_seed  out  96  seed for the PRNG (drives prng in_seed).
REQ-010 prng_mod  out  1  PRNG seed-select; SHALL be 1 whenever prng_req=1.
REQ-011 prng_rdy  in  1  PRNG output strobe (prng out_ready).
REQ-012 prng_data  in  96  PRNG result (prng out_rng).
REQ-013 rnd_valid  out  1  rnd_data is valid.
REQ-014 rnd_ready  in  1  consumer accepts the word.
REQ-015 rnd_data  out  W  random word.
REQ-016 level  out  2  number of full 96-bit blocks buffered (0..2).
REQ-017 err  out  1  sticky PRNG-timeout flag.

Function
REQ-018 SHALL have FSM states UNSEEDED, REQ, WAIT and HOLD.
REQ-019 UNSEEDED: SHALL issue no requests; on seed_load, state_reg <= seed and go to REQ.
REQ-020 REQ: SHALL assert prng_req=1 for exactly one cycle with prng_seed=state_reg, then go to WAIT.
REQ-021 WAIT: on prng_rdy=1, SHALL write prng_data into the buffer tail, set state_reg <= prng_data (chained reseed), and go to REQ if level after the write is <2, else to HOLD.
REQ-022 HOLD: SHALL go to REQ in the cycle after level drops below 2.
REQ-023 At most one PRNG request SHALL be outstanding; prng_rdy outside WAIT SHALL be ignored.
REQ-024 Buffer SHALL be a 2-entry FIFO of 96-bit blocks; a capture and a pop in the same cycle SHALL both take effect.
REQ-025 rnd_valid SHALL equal (level != 0).
REQ-026 rnd_data SHALL be word k of the head block, head[95-W*k -: W], with k = 0..N-1 (MSB first).
REQ-027 A handshake (rnd_valid & rnd_ready) SHALL advance k; at k = N-1 the handshake SHALL pop the head and reset k to 0.
REQ-028 rnd_data SHALL hold stable while rnd_valid=1 and rnd_ready=0.
REQ-029 Timeout: a counter SHALL run in WAIT; when TIMEOUT cycles elapse without prng_rdy, err SHALL be set and the FSM SHALL go to REQ (retry with the same state_reg).
REQ-030 seed_load in REQ or HOLD SHALL flush the buffer, reset k, load state_reg, clear err, and go to REQ.
REQ-031 seed_load in WAIT SHALL flush, load state_reg and clear err; the in-flight response SHALL then be discarded, after which the FSM goes to REQ.
REQ-032 seed_load coincident with a handshake: the word SHALL count as delivered, then the flush SHALL apply.
REQ-033 seed_load coincident with prng_rdy in WAIT: the response SHALL be discarded.
REQ-034 A second seed_load during WAIT SHALL overwrite state_reg; only one response SHALL be discarded.

Reset
REQ-035 On rst: state UNSEEDED, state_reg=0, buffer empty, k=0, timeout counter=0.
REQ-036 On rst: prng_req=0, prng_mod=0, prng_seed=0, rnd_valid=0, rnd_data=0, level=0, err=0.
REQ-037 Reset mid-WAIT SHALL abandon the request; a later prng_rdy SHALL be ignored while UNSEEDED.

Verification
REQ-038 Bench SHALL use a stub PRNG returning data = {seed[94:0], seed[95]} ^ 96'hA5 after 20 cycles, with W=32.
REQ-039 No seed_load for 100 cycles -> prng_req never asserted, rnd_valid=0, level=0.
REQ-040 seed=96'h1, rnd_ready=0 -> exactly two requests, level=2, HOLD; rnd_data = word 0 of block 1, stable throughout.
REQ-041 rnd_ready=1 held for 6 words -> words follow MSB-first order across block1 and block2; the third request is issued one cycle after the first pop; block2 is derived from block1.
REQ-042 Stub silent -> err=1 exactly 64 cycles after WAIT entry; retry prng_req the next cycle; err persists until seed_load.
REQ-043 seed_load 5 cycles into WAIT -> the old response is dropped, a new prng_req carries the new seed, and rnd_valid=0 until the new block arrives.
REQ-044 seed_load coincident with handshake of word 1 -> that word is consumed once; level=0 afterwards; no stale words appear.

Source files
------------

// File: rtl/rng_dispenser.sv
// rng_dispenser: keeps up to two 96-bit PRNG blocks buffered and hands them out as W-bit words.
module rng_dispenser #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          seed_load,
  input  logic [95:0]   seed,
  output logic          prng_req,
  output logic [95:0]   prng_seed,
  output logic          prng_mod,
  input  logic          prng_rdy,
  input  logic [95:0]   prng_data,
  output logic          rnd_valid,
  input  logic          rnd_ready,
  output logic [W-1:0]  rnd_data,
  output logic [1:0]    level,
  output logic          err
);

  localparam int unsigned BW = 96;
  localparam int unsigned N  = BW / W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {UNSEEDED, REQ, WAIT, HOLD} state_t;

  state_t          st, st_nxt;
  logic [BW-1:0]   sreg, sreg_nxt;
  logic [BW-1:0]   b0, b0_nxt;
  logic [BW-1:0]   b1, b1_nxt;
  logic [1:0]      lvl_nxt, lvl_pop;
  logic [KW-1:0]   k, k_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic            err_nxt;
  logic            disc, disc_nxt;
  logic            hs, rsp, tmo;

  // Word k of a block, MSB-first.
  function automatic logic [W-1:0] pick(input logic [BW-1:0] blk, input logic [KW-1:0] idx);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx == KW'(i)) w = blk[BW-1-W*i -: W];
    end
    return w;
  endfunction

  // Next-state: consumer pop first, then PRNG capture, then seed_load flush on top.
  always_comb begin
    st_nxt   = st;
    sreg_nxt = sreg;
    b0_nxt   = b0;
    b1_nxt   = b1;
    lvl_nxt  = level;
    k_nxt    = k;
    tmr_nxt  = '0;
    err_nxt  = err;
    disc_nxt = disc;
    hs       = rnd_valid & rnd_ready;
    rsp      = (st == WAIT) & prng_rdy;
    tmo      = (st == WAIT) & ~prng_rdy & (tmr == TW'(TIMEOUT - 1));

    if (hs) begin
      if (k == KW'(N - 1)) begin
        k_nxt   = '0;
        b0_nxt  = b1;
        lvl_nxt = level - 2'd1;
      end else begin
        k_nxt = k + KW'(1);
      end
    end
    lvl_pop = lvl_nxt;

    case (st)
      UNSEEDED: begin
        st_nxt = UNSEEDED;
      end
      REQ: begin
        st_nxt = WAIT;
      end
      WAIT: begin
        tmr_nxt = tmr + TW'(1);
        if (rsp) begin
          tmr_nxt  = '0;
          st_nxt   = REQ;
          disc_nxt = 1'b0;
          if (!disc) begin
            if (lvl_pop == 2'd0) b0_nxt = prng_data;
            else                 b1_nxt = prng_data;
            lvl_nxt  = lvl_pop + 2'd1;
            sreg_nxt = prng_data;
            if (lvl_nxt == 2'd2) st_nxt = HOLD;
          end
        end else if (tmo) begin
          tmr_nxt  = '0;
          err_nxt  = 1'b1;
          st_nxt   = REQ;
          disc_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (lvl_pop != 2'd2) st_nxt = REQ;
      end
      default: begin
        st_nxt = UNSEEDED;
      end
    endcase

    if (seed_load) begin
      sreg_nxt = seed;
      lvl_nxt  = 2'd0;
      k_nxt    = '0;
      err_nxt  = 1'b0;
      case (st)
        // The request pulse is already on the wire this cycle; its answer must be dropped.
        REQ: begin
          st_nxt   = WAIT;
          disc_nxt = 1'b1;
        end
        // A response (or timeout) this cycle ends the in-flight request right away.
        WAIT: begin
          if (rsp || tmo) begin
            st_nxt   = REQ;
            disc_nxt = 1'b0;
          end else begin
            st_nxt   = WAIT;
            disc_nxt = 1'b1;
          end
        end
        default: begin
          st_nxt   = REQ;
          disc_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= UNSEEDED;
      sreg      <= '0;
      b0        <= '0;
      b1        <= '0;
      k         <= '0;
      tmr       <= '0;
      disc      <= 1'b0;
      prng_req  <= 1'b0;
      prng_mod  <= 1'b0;
      prng_seed <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      level     <= 2'd0;
      err       <= 1'b0;
    end else begin
      st        <= st_nxt;
      sreg      <= sreg_nxt;
      b0        <= b0_nxt;
      b1        <= b1_nxt;
      k         <= k_nxt;
      tmr       <= tmr_nxt;
      disc      <= disc_nxt;
      prng_req  <= (st_nxt == REQ);
      prng_mod  <= (st_nxt == REQ);
      prng_seed <= sreg_nxt;
      rnd_valid <= (lvl_nxt != 2'd0);
      rnd_data  <= (lvl_nxt != 2'd0) ? pick(b0_nxt, k_nxt) : '0;
      level     <= lvl_nxt;
      err       <= err_nxt;
    end
  end

endmodule
